// File: rtl/simple_bus_pkg.sv
// Shared types and defaults for the simple-bus arbiter: FSM state encoding,
// default timeouts and the phase counter sizing helper.
package simple_bus_pkg;

  localparam int DEF_NUM_MASTERS   = 4;
  localparam int DEF_START_TIMEOUT = 8;
  localparam int DEF_DV_TIMEOUT    = 16;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t ARB_IDLE    = 3'd0;
  localparam arb_state_t ARB_GRANT   = 3'd1;
  localparam arb_state_t ARB_ADDR_LO = 3'd2;
  localparam arb_state_t ARB_RD_WAIT = 3'd3;
  localparam arb_state_t ARB_WR_WAIT = 3'd4;

  // One spare bit above the larger timeout so the counter can saturate cleanly.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/simple_bus_arbiter_if.sv
// Request/grant and snooped bus-control bundle between the masters and the arbiter.
// master: a requester/bus side view; slave: the arbiter's view.
interface simple_bus_arbiter_if
  import simple_bus_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS
);
  localparam int IDW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] gnt;
  logic [IDW-1:0]         gnt_id;
  logic                   bus_busy;
  logic                   start;
  logic                   read;
  logic                   dataValid;
  logic                   timeout_err;

  modport master (
    output req, start, read, dataValid,
    input  gnt, gnt_id, bus_busy, timeout_err
  );

  modport slave (
    input  req, start, read, dataValid,
    output gnt, gnt_id, bus_busy, timeout_err
  );

endinterface

// File: rtl/simple_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after rr_ptr,
// wrapping around NUM_MASTERS.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    int          j;
    logic [IW-1:0] cand;
    j     = 0;
    cand  = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= N) j = j - N;
      cand = IW'(j);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/simple_bus_arbiter.sv
// Round-robin owner of the shared tri-state simple bus; tracks each transaction by
// snooping start/read/dataValid and releases on completion, request drop or timeout.
module simple_bus_arbiter
  import simple_bus_pkg::*;
#(
  parameter int NUM_MASTERS   = DEF_NUM_MASTERS,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT,
  parameter int DV_TIMEOUT    = DEF_DV_TIMEOUT
) (
  input logic                clock,
  input logic                reset,
  simple_bus_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = cnt_width(START_TIMEOUT, DV_TIMEOUT);

  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] DV_LAST    = CW'(DV_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [IW-1:0] LAST_ID    = IW'(NUM_MASTERS - 1);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IW-1:0]          gnt_id_q, gnt_id_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   timeout_err_q, timeout_err_d;

  logic                   pick_valid;
  logic [IW-1:0]          pick_idx;
  logic [CW-1:0]          cnt_inc;
  logic                   rel;

  rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    gnt_id_d      = gnt_id_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
    rel           = 1'b0;
    cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Completion events are tested before the timeout so a tie never flags an error.
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d         = ARB_GRANT;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          gnt_id_d        = pick_idx;
          cnt_d           = '0;
        end
      end
      ARB_GRANT: begin
        if (bus.start) begin
          state_d = ARB_ADDR_LO;
          cnt_d   = '0;
        end else if (!bus.req[gnt_id_q]) begin
          rel = 1'b1;
        end else if (cnt_q >= START_LAST) begin
          rel           = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ARB_ADDR_LO: begin
        state_d = bus.read ? ARB_RD_WAIT : ARB_WR_WAIT;
        cnt_d   = '0;
      end
      ARB_RD_WAIT, ARB_WR_WAIT: begin
        if (bus.dataValid) begin
          rel = 1'b1;
        end else if (cnt_q >= DV_LAST) begin
          rel           = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: rel = 1'b1;
    endcase

    // Release always passes through ARB_IDLE, giving the bus a turnaround cycle.
    if (rel) begin
      state_d  = ARB_IDLE;
      gnt_d    = '0;
      gnt_id_d = '0;
      cnt_d    = '0;
      rr_ptr_d = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ARB_IDLE;
      gnt_q         <= '0;
      gnt_id_q      <= '0;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      gnt_id_q      <= gnt_id_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.gnt_id      = gnt_id_q;
  assign bus.bus_busy    = |gnt_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// Cycle-level bench for simple_bus_arbiter: per-cycle stimulus with expected
// grant/error pushed to a scoreboard and checked just after each rising edge.
module tb_simple_bus_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  simple_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

  simple_bus_arbiter #(
    .NUM_MASTERS   (N),
    .START_TIMEOUT (8),
    .DV_TIMEOUT    (16)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [3:0] gnt;
    logic       terr;
    string      name;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic       start;
    logic       read;
    logic       dv;
    logic [3:0] gnt;
    logic       terr;
  } vec_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  bit   inv_en = 1'b0;

  task automatic step(input logic r, input logic [3:0] rq, input logic s, input logic rd,
                      input logic dv, input logic [3:0] eg, input logic et, input string nm);
    @(negedge clk);
    rst           = r;
    bus.req       = rq;
    bus.start     = s;
    bus.read      = rd;
    bus.dataValid = dv;
    sb_q.push_back('{gnt: eg, terr: et, name: nm});
  endtask

  // Scoreboard: outputs registered at this edge against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t       e;
      logic [1:0] eid;
      e   = sb_q.pop_front();
      eid = '0;
      for (int i = 0; i < N; i++) if (e.gnt[i]) eid = 2'(i);
      n_vec++;
      if (bus.gnt !== e.gnt || bus.gnt_id !== eid || bus.bus_busy !== (|e.gnt) ||
          bus.timeout_err !== e.terr) begin
        n_err++;
        $display("FAIL %s: got gnt=%b id=%0d busy=%b terr=%b, want gnt=%b id=%0d busy=%b terr=%b",
                 e.name, bus.gnt, bus.gnt_id, bus.bus_busy, bus.timeout_err,
                 e.gnt, eid, |e.gnt, e.terr);
      end
    end
  end

  always @(negedge clk) begin
    if (inv_en) begin
      n_vec++;
      if (!$onehot0(bus.gnt) || bus.bus_busy !== (|bus.gnt) ||
          (bus.gnt != 4'b0 && bus.gnt[bus.gnt_id] !== 1'b1) ||
          (bus.gnt == 4'b0 && bus.gnt_id !== 2'd0)) begin
        n_err++;
        $display("FAIL invariant: gnt=%b id=%0d busy=%b, need onehot0 gnt, id matching gnt, busy==|gnt",
                 bus.gnt, bus.gnt_id, bus.bus_busy);
      end
    end
  end

  initial begin
    vec_t tbl[8];

    rst           = 1'b1;
    bus.req       = '0;
    bus.start     = 1'b0;
    bus.read      = 1'b0;
    bus.dataValid = 1'b0;

    // Reset held two cycles with every master requesting.
    step(1, 4'hF, 0, 0, 0, 4'h0, 0, "reset_c1");
    step(1, 4'hF, 0, 0, 0, 4'h0, 0, "reset_c2");
    inv_en = 1'b1;
    step(0, 4'h0, 0, 0, 0, 4'h0, 0, "post_reset_idle");

    // Single read by master 1; dataValid in GRANT and start in RD_WAIT are ignored.
    tbl[0] = '{req: 4'b0010, start: 0, read: 0, dv: 0, gnt: 4'b0010, terr: 0};
    tbl[1] = '{req: 4'b0010, start: 0, read: 0, dv: 1, gnt: 4'b0010, terr: 0};
    tbl[2] = '{req: 4'b0010, start: 1, read: 0, dv: 0, gnt: 4'b0010, terr: 0};
    tbl[3] = '{req: 4'b0010, start: 0, read: 1, dv: 0, gnt: 4'b0010, terr: 0};
    tbl[4] = '{req: 4'b0010, start: 1, read: 0, dv: 0, gnt: 4'b0010, terr: 0};
    tbl[5] = '{req: 4'b0010, start: 0, read: 0, dv: 0, gnt: 4'b0010, terr: 0};
    tbl[6] = '{req: 4'b0010, start: 0, read: 0, dv: 1, gnt: 4'b0000, terr: 0};
    tbl[7] = '{req: 4'b0000, start: 0, read: 0, dv: 0, gnt: 4'b0000, terr: 0};
    for (int i = 0; i < 8; i++)
      step(0, tbl[i].req, tbl[i].start, tbl[i].read, tbl[i].dv, tbl[i].gnt, tbl[i].terr,
           $sformatf("read_v%0d", i));

    // Round robin from a fresh pointer: order 0,1,2,3,0 with one idle cycle between owners.
    step(1, 4'h0, 0, 0, 0, 4'h0, 0, "rr_reset");
    for (int k = 0; k < 5; k++) begin
      logic [3:0] eg;
      eg = 4'(1 << (k % 4));
      step(0, 4'hF, 0, 0, 0, eg,   0, $sformatf("rr_grant%0d", k));
      step(0, 4'hF, 1, 0, 0, eg,   0, $sformatf("rr_start%0d", k));
      step(0, 4'hF, 0, 0, 0, eg,   0, $sformatf("rr_addr%0d", k));
      step(0, 4'hF, 0, 0, 1, 4'h0, 0, $sformatf("rr_done%0d", k));
    end

    // Start timeout on master 2: eight granted cycles, then revoke with an error pulse.
    step(0, 4'b0100, 0, 0, 0, 4'b0100, 0, "sto_grant");
    for (int i = 1; i < 8; i++)
      step(0, 4'b0100, 0, 0, 0, 4'b0100, 0, $sformatf("sto_hold%0d", i));
    step(0, 4'b0100, 0, 0, 0, 4'b0000, 1, "sto_revoke");
    step(0, 4'hF,    0, 0, 0, 4'b1000, 0, "sto_next_m3");
    step(0, 4'h0,    0, 0, 0, 4'b0000, 0, "grant_req_drop");

    // Data-valid timeout on a read; dropping req while waiting must not release.
    step(0, 4'b0001, 0, 0, 0, 4'b0001, 0, "dvto_grant");
    step(0, 4'b0001, 1, 0, 0, 4'b0001, 0, "dvto_start");
    step(0, 4'b0001, 0, 1, 0, 4'b0001, 0, "dvto_addr");
    for (int i = 1; i < 16; i++)
      step(0, 4'b0000, 0, 0, 0, 4'b0001, 0, $sformatf("dvto_wait%0d", i));
    step(0, 4'b0000, 0, 0, 0, 4'b0000, 1, "dvto_abort");
    step(0, 4'b0000, 0, 0, 0, 4'b0000, 0, "dvto_pulse_end");

    // Completion on the last counted cycle wins over the timeout in both phases.
    step(0, 4'b0010, 0, 0, 0, 4'b0010, 0, "tie_grant");
    for (int i = 1; i < 8; i++)
      step(0, 4'b0010, 0, 0, 0, 4'b0010, 0, $sformatf("tie_hold%0d", i));
    step(0, 4'b0010, 1, 0, 0, 4'b0010, 0, "tie_start");
    step(0, 4'b0010, 0, 0, 0, 4'b0010, 0, "tie_addr");
    for (int i = 1; i < 16; i++)
      step(0, 4'b0010, 0, 0, 0, 4'b0010, 0, $sformatf("tie_wait%0d", i));
    step(0, 4'b0010, 0, 0, 1, 4'b0000, 0, "tie_dv");

    // Reset during a write wait: grant drops, pointer returns to master 0.
    step(0, 4'hF, 0, 0, 0, 4'b0100, 0, "mrst_grant");
    step(0, 4'hF, 1, 0, 0, 4'b0100, 0, "mrst_start");
    step(0, 4'hF, 0, 0, 0, 4'b0100, 0, "mrst_addr");
    step(0, 4'hF, 0, 0, 0, 4'b0100, 0, "mrst_wait");
    step(1, 4'hF, 0, 0, 0, 4'b0000, 0, "mrst_reset");
    step(0, 4'hF, 0, 0, 0, 4'b0001, 0, "mrst_rr_ptr0");
    step(0, 4'h0, 0, 0, 0, 4'b0000, 0, "mrst_release");

    repeat (3) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
